// File: rtl/adder_seq_pkg.sv
// adder_seq_pkg: shared types and helpers for the byte-serial adder sequencer.
package adder_seq_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int idx_width(input int nbytes);
        return (nbytes <= 1) ? 1 : $clog2(nbytes);
    endfunction

endpackage

// File: rtl/adder_8bit.sv
// adder_8bit: shared 8-bit ripple adder used as the byte datapath.
module adder_8bit (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {8'b0, cin};

endmodule

// File: rtl/adder_seq_ctrl.sv
// adder_seq_ctrl: wide add done one byte per cycle on a shared adder_8bit, LSB first.
// Define ADDSEQ_SUB_EN to add the op_sub port (result = op_a - op_b).
module adder_seq_ctrl
    import adder_seq_pkg::*;
#(
    parameter  int NBYTES = 4,
    localparam int W      = BYTE_W * NBYTES
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start_valid,
    output logic         start_ready,
    input  logic [W-1:0] op_a,
    input  logic [W-1:0] op_b,
    input  logic         cin,
`ifdef ADDSEQ_SUB_EN
    input  logic         op_sub,
`endif
    output logic         res_valid,
    input  logic         res_ready,
    output logic [W-1:0] result,
    output logic         cout,
    output logic         busy
);

    localparam int IW = idx_width(NBYTES);
    localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

    state_t            state;
    logic [IW-1:0]     idx;
    logic              carry;
    logic [W-1:0]      a_reg;
    logic [W-1:0]      b_reg;
    logic [BYTE_W-1:0] sum;
    logic              add_cout;
    logic              sub;

`ifdef ADDSEQ_SUB_EN
    assign sub = op_sub;
`else
    assign sub = 1'b0;
`endif

    assign start_ready = (state == IDLE);

    adder_8bit u_add (
        .a    (a_reg[BYTE_W*idx +: BYTE_W]),
        .b    (b_reg[BYTE_W*idx +: BYTE_W]),
        .cin  (carry),
        .sum  (sum),
        .cout (add_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            carry     <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            result    <= '0;
            cout      <= 1'b0;
            res_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start_valid) begin
                    a_reg  <= op_a;
                    // Subtraction is a + ~b + 1, so the inverted operand and forced carry live here.
                    b_reg  <= sub ? ~op_b : op_b;
                    carry  <= sub ? 1'b1 : cin;
                    idx    <= '0;
                    result <= '0;
                    cout   <= 1'b0;
                    busy   <= 1'b1;
                    state  <= RUN;
                end
                RUN: begin
                    result[BYTE_W*idx +: BYTE_W] <= sum;
                    carry <= add_cout;
                    if (idx == LAST) begin
                        cout      <= add_cout;
                        res_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: if (res_ready) begin
                    res_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// tb_adder_seq_ctrl: directed checks of the byte-serial adder sequencer (NBYTES=4).
module tb_adder_seq_ctrl;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start_valid = 1'b0;
    logic         start_ready;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         cin = 1'b0;
    logic         op_sub = 1'b0;
    logic         res_valid;
    logic         res_ready = 1'b0;
    logic [W-1:0] result;
    logic         cout;
    logic         busy;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    adder_seq_ctrl #(.NBYTES(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .op_a        (op_a),
        .op_b        (op_b),
        .cin         (cin),
`ifdef ADDSEQ_SUB_EN
        .op_sub      (op_sub),
`endif
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .result      (result),
        .cout        (cout),
        .busy        (busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " start_ready"}, 64'(start_ready), 64'd1);
        check({tag, " res_valid"}, 64'(res_valid), 64'd0);
        check({tag, " result"}, 64'(result), 64'd0);
        check({tag, " cout"}, 64'(cout), 64'd0);
        check({tag, " busy"}, 64'(busy), 64'd0);
    endtask

    // Wait (bounded) for res_valid; returns negedges counted after the accept edge.
    task automatic wait_result(output int n);
        n = 0;
        while (!res_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Called at a negedge in IDLE: presents one request, returns after the accept edge.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input logic s);
        check("ready before accept", 64'(start_ready), 64'd1);
        op_a = a;
        op_b = b;
        cin = c;
        op_sub = s;
        start_valid = 1'b1;
        @(negedge clk);
        check("busy after accept", 64'(busy), 64'd1);
    endtask

    task automatic drain;
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check("idle after drain", 64'(start_ready), 64'd1);
    endtask

    initial begin
        int n;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rc;
        logic [W:0]   exp;

        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // 0xFF + 0x01: carry crosses into byte 1, latency 4
        issue(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
        start_valid = 1'b0;
        check("no early valid", 64'(res_valid), 64'd0);
        wait_result(n);
        check("latency t1", 64'(n), 64'd4);
        check("result t1", 64'(result), 64'h0000_0100);
        check("cout t1", 64'(cout), 64'd0);
        drain();
        check("busy low t1", 64'(busy), 64'd0);

        // all-ones + cin ripples through every byte
        issue(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0);
        start_valid = 1'b0;
        wait_result(n);
        check("latency t2", 64'(n), 64'd4);
        check("result t2", 64'(result), 64'h0);
        check("cout t2", 64'(cout), 64'd1);
        drain();

        // backpressure with start_valid held; later operands must not leak in
        issue(32'h0102_0304, 32'h1020_3040, 1'b0, 1'b0);
        op_a = 32'h8000_0000;
        op_b = 32'h8000_0000;
        cin = 1'b1;
        cin = 1'b0;
        wait_result(n);
        check("latency t3", 64'(n), 64'd4);
        for (int i = 0; i < 10; i++) begin
            check("hold result", 64'(result), 64'h1122_3344);
            check("hold cout", 64'(cout), 64'd0);
            check("hold not ready", 64'(start_ready), 64'd0);
            check("hold valid", 64'(res_valid), 64'd1);
            @(negedge clk);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check("t3 back to idle", 64'(start_ready), 64'd1);
        check("t3 valid dropped", 64'(res_valid), 64'd0);
        @(negedge clk);
        check("t3 second accept", 64'(busy), 64'd1);
        check("t3 not ready", 64'(start_ready), 64'd0);
        start_valid = 1'b0;
        wait_result(n);
        check("result t3b", 64'(result), 64'h0);
        check("cout t3b", 64'(cout), 64'd1);
        drain();

        // reset two cycles into RUN discards the operation
        issue(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
        start_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid-run reset");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("no valid in reset", 64'(res_valid), 64'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check("no valid after reset", 64'(res_valid), 64'd0);
        issue(32'd1, 32'd2, 1'b0, 1'b0);
        start_valid = 1'b0;
        wait_result(n);
        check("latency t4", 64'(n), 64'd4);
        check("result t4", 64'(result), 64'h3);
        check("cout t4", 64'(cout), 64'd0);
        drain();

        // back-to-back with both handshakes tied high: one op per 6 cycles
        res_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ra = $urandom;
            rb = $urandom;
            rc = 1'($urandom_range(0, 1));
            if (i == 0) begin
                ra = 32'hFFFF_0000;
                rb = 32'h0001_FFFF;
            end
            exp = {1'b0, ra} + {1'b0, rb} + {32'd0, rc};
            issue(ra, rb, rc, 1'b0);
            wait_result(n);
            check("latency t5", 64'(n), 64'd4);
            check("result t5", 64'(result), 64'(exp[W-1:0]));
            check("cout t5", 64'(cout), 64'(exp[W]));
            @(negedge clk);
            check("reaccept slot t5", 64'(start_ready), 64'd1);
        end
        start_valid = 1'b0;
        res_ready = 1'b0;
        @(negedge clk);

`ifdef ADDSEQ_SUB_EN
        issue(32'd5, 32'd7, 1'b0, 1'b1);
        start_valid = 1'b0;
        op_sub = 1'b0;
        wait_result(n);
        check("result sub 5-7", 64'(result), 64'hFFFF_FFFE);
        check("cout sub 5-7", 64'(cout), 64'd0);
        drain();
        issue(32'd7, 32'd5, 1'b1, 1'b1);
        start_valid = 1'b0;
        op_sub = 1'b0;
        wait_result(n);
        check("result sub 7-5", 64'(result), 64'h2);
        check("cout sub 7-5", 64'(cout), 64'd1);
        drain();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/adder_seq_ctrl.md
Name: adder_seq_ctrl

Overview:
Sequencer that performs a wide (8*NBYTES-bit) addition by time-multiplexing a single adder_8bit instance, one byte per cycle, LSB byte first. The carry is held in a register between bytes. Operands are accepted and results returned through valid/ready handshakes. It sits between a requesting datapath and the shared 8-bit ripple adder.

Parameters:
NBYTES, 4, operand width in bytes; legal range 1..16; W = 8*NBYTES.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start_valid  input  1  request valid
start_ready  output  1  block can accept a request
op_a  input  W  operand A, sampled on the accept handshake
op_b  input  W  operand B, sampled on the accept handshake
cin  input  1  carry-in to byte 0, sampled on the accept handshake
res_valid  output  1  result valid
res_ready  input  1  consumer accepts the result
result  output  W  sum
cout  output  1  carry out of the top byte
busy  output  1  high in RUN or DONE

Behaviour:
- Single clock clk; reset rst_n is asynchronous, active-low.
- Reset values:
  - state=IDLE; start_ready=1; res_valid=0; result=0; cout=0; busy=0.
  - Internal: byte index=0, carry register=0, operand registers=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start_ready=1.
  - On start_valid&&start_ready: capture op_a, op_b and cin (cin loads the carry register); idx<=0; clear result; go to RUN.
- RUN:
  - start_ready=0.
  - Each cycle, adder_8bit gets a_reg[8*idx+:8], b_reg[8*idx+:8] and the carry register.
  - Its sum is written to result[8*idx+:8]; its cout loads the carry register.
  - If idx==NBYTES-1: cout<=adder cout, go to DONE. Otherwise idx<=idx+1.
- DONE:
  - res_valid=1; result and cout held stable.
  - On res_ready: res_valid<=0, go to IDLE.
- Latency: accept at edge k, res_valid rises after edge k+NBYTES. Throughput is one operation per NBYTES+2 cycles with res_ready tied high.
- start_ready is asserted only in IDLE. No overlap of requests; start_valid in RUN/DONE is ignored, not queued.
- Operand or cin changes after acceptance have no effect.
- Arithmetic is modulo 2^W; the carry out of the top byte goes only to cout.
- NBYTES=1: RUN lasts exactly one cycle.
- result is partially updated during RUN; it is valid only while res_valid=1.
- Reset asserted in any state: immediate return to reset values; the in-flight operation is discarded, with no res_valid pulse.
- All outputs are registered, with no combinational path from inputs to outputs, except that start_ready is a decode of the state register.

Optional Feature:
Macro ADDSEQ_SUB_EN.
- Defined:
  - Extra input port op_sub (1 bit), sampled with the operands.
  - op_sub=1: b_reg <= ~op_b and the carry register <= 1 (cin ignored), giving result = op_a - op_b.
  - In subtract mode, cout=1 means no borrow.
  - op_sub=0: behaviour identical to the undefined case.
- Undefined: no op_sub port; add only.

Decomposition:
- Package adder_seq_pkg:
  - State enum typedef (IDLE, RUN, DONE).
  - Localparam for the byte width (8).
  - Function computing the index width, $clog2(NBYTES) with a minimum of 1.
- Sub-module: one adder_8bit instance, the existing block, used as the shared byte datapath. No other sub-modules; the FSM, index counter and carry register are inline.

Test Plan:
- NBYTES=4, a=0x000000FF, b=0x00000001, cin=0 -> result=0x00000100, cout=0, res_valid exactly 4 cycles after the accept edge.
- a=0xFFFFFFFF, b=0x00000000, cin=1 -> result=0x00000000, cout=1 (carry ripples through all 4 bytes via the carry register).
- Result ready, res_ready held low 10 cycles, start_valid=1 throughout -> result/cout stable, start_ready=0, no second accept. Raise res_ready -> accept in IDLE the following cycle.
- Assert rst_n=0 two cycles into RUN (a=0x12345678, b=0x11111111) -> all outputs at reset values immediately. Next op a=1, b=2, cin=0 -> result=0x00000003, cout=0.
- res_ready and start_valid tied high, 3 random ops -> each accepted every 6 cycles; results match the golden model (a+b+cin) mod 2^32 with matching carry.
- ADDSEQ_SUB_EN defined, a=5, b=7, op_sub=1 -> result=0xFFFFFFFE, cout=0. a=7, b=5 -> result=0x00000002, cout=1.
